// File: rtl/prog_clk_divider_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : prog_clk_divider_if                                    |
// | Purpose : Configuration and output bundle of prog_clk_divider    |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
interface prog_clk_divider_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div_val;
    logic [1:0]       mode_val;
    logic             div_load;
    logic [WIDTH-1:0] count;
    logic             fout;
    logic             tick;
    logic             load_pending;

    modport master (
        output en, div_val, mode_val, div_load,
        input  count, fout, tick, load_pending
    );

    modport slave (
        input  en, div_val, mode_val, div_load,
        output count, fout, tick, load_pending
    );
endinterface
`default_nettype wire

// File: rtl/prog_clk_divider.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : prog_clk_divider                                       |
// | Purpose : Programmable clock-enable divider, wrap-aligned reload |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module prog_clk_divider #(
    parameter int WIDTH        = 8,
    parameter int DEFAULT_DIV  = 7,
    parameter int DEFAULT_MODE = 0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    prog_clk_divider_if.slave  bus
);
    localparam logic [1:0]       c_mode_toggle  = 2'd0;
    localparam logic [1:0]       c_mode_pulse   = 2'd1;
    localparam logic [1:0]       c_mode_square  = 2'd2;
    localparam logic [WIDTH-1:0] c_default_div  = DEFAULT_DIV[WIDTH-1:0];
    localparam logic [1:0]       c_default_mode = DEFAULT_MODE[1:0];
    localparam logic [WIDTH-1:0] c_one          = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_div;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_sh_div;
    logic [1:0]       r_sh_mode;
    logic             r_pending;
    logic [WIDTH-1:0] r_count;
    logic             r_fout;
    logic             r_tick;

    logic             w_stopped;
    logic             w_wrap;
    logic             w_apply;
    logic [WIDTH-1:0] w_next_div;
    logic [1:0]       w_next_mode;
    logic [WIDTH-1:0] w_div_eff;
    logic [1:0]       w_mode_eff;
    logic [WIDTH-1:0] w_next_count;
    logic [WIDTH:0]   w_half;
    logic             w_square;

    always_comb begin
        w_stopped    = (r_div == '0);
        w_wrap       = bus.en && !w_stopped && (r_count == (r_div - c_one));
        // A stopped divider has no wrap to wait for, so it reloads on any edge.
        w_apply      = (w_wrap || w_stopped) && (r_pending || bus.div_load);
        w_next_div   = bus.div_load ? bus.div_val  : r_sh_div;
        w_next_mode  = bus.div_load ? bus.mode_val : r_sh_mode;
        if (w_next_mode == 2'd3) begin
            w_next_mode = c_mode_toggle;
        end
        w_div_eff    = w_apply ? w_next_div  : r_div;
        w_mode_eff   = w_apply ? w_next_mode : r_mode;
        w_next_count = w_wrap ? '0 : (r_count + c_one);
        // One extra bit keeps N+1 from overflowing at the largest modulus.
        w_half       = ({1'b0, w_div_eff} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
        w_square     = ({1'b0, w_next_count} < w_half);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div     <= c_default_div;
            r_mode    <= c_default_mode;
            r_sh_div  <= '0;
            r_sh_mode <= '0;
            r_pending <= 1'b0;
            r_count   <= '0;
            r_fout    <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            if (bus.div_load) begin
                r_sh_div  <= bus.div_val;
                r_sh_mode <= bus.mode_val;
            end

            if (w_apply) begin
                r_pending <= 1'b0;
                r_div     <= w_next_div;
                r_mode    <= w_next_mode;
            end else if (bus.div_load) begin
                r_pending <= 1'b1;
            end

            if (w_stopped) begin
                r_count <= '0;
                r_fout  <= 1'b0;
                r_tick  <= 1'b0;
            end else if (!bus.en) begin
                r_tick  <= 1'b0;
            end else begin
                r_count <= w_next_count;
                r_tick  <= w_wrap;
                if (w_wrap && (w_div_eff == '0)) begin
                    r_fout <= 1'b0;
                end else begin
                    case (w_mode_eff)
                        c_mode_toggle: if (w_wrap) r_fout <= ~r_fout;
                        c_mode_pulse:  r_fout <= w_wrap;
                        c_mode_square: r_fout <= w_square;
                        default:       r_fout <= r_fout;
                    endcase
                end
            end
        end
    end

    assign bus.count        = r_count;
    assign bus.fout         = r_fout;
    assign bus.tick         = r_tick;
    assign bus.load_pending = r_pending;
endmodule
`default_nettype wire
